// File: rtl/note_seq_ram.sv
// ---------------------------------------------------------------------------
// note_seq_ram
//
// Multi-channel note memory. A single write port loads songs into a shared
// 2^ADDR_W x DATA_W array. Each of NCH playback channels walks its own song
// (base address + length), holds each note for its duration in beats and
// presents the current note word to its tone generator.
//
// Note word layout:
//   [DATA_W-1 : DATA_W-4]  pitch
//   [DATA_W-5 : DUR_W]     octave
//   [DUR_W-1  : 0]         duration in beats (0 = end-of-song marker)
// DATA_W must be at least DUR_W+7 so that pitch and octave both fit.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset (memory contents are kept)
//   wr_en      write strobe
//   wr_addr    write address
//   wr_data    note word to write
//   beat_tick  one-cycle beat pulse shared by all channels
//   ch_start   per-channel start pulse
//   ch_stop    per-channel stop pulse (wins over ch_start)
//   ch_loop    per-channel loop enable, sampled on start
//   ch_base    per-channel song base address, sampled on start
//   ch_len     per-channel song length in notes, sampled on start
//   ch_note    current note word per channel
//   ch_valid   per-channel: ch_note is playing
//   ch_done    per-channel one-cycle pulse when a non-looping song ends
//   ch_busy    per-channel: state machine not idle
// ---------------------------------------------------------------------------
module note_seq_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8,
  parameter int NCH    = 2,
  parameter int DUR_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    beat_tick,
  input  logic [NCH-1:0]          ch_start,
  input  logic [NCH-1:0]          ch_stop,
  input  logic [NCH-1:0]          ch_loop,
  input  logic [NCH*ADDR_W-1:0]   ch_base,
  input  logic [NCH*ADDR_W-1:0]   ch_len,
  output logic [NCH*DATA_W-1:0]   ch_note,
  output logic [NCH-1:0]          ch_valid,
  output logic [NCH-1:0]          ch_done,
  output logic [NCH-1:0]          ch_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE = DUR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY
  } state_t;

  // -------------------------------------------------------------------------
  // Shared note store
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the memory array has no reset branch on purpose: songs survive rst,
  // and a reset loop over the whole array would prevent RAM inference.
  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Playback channels
  // -------------------------------------------------------------------------
  for (genvar c = 0; c < NCH; c++) begin : g_ch

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_rem;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_len;
    logic                r_loop;
    logic [DUR_W-1:0]    r_dur;
    logic [DATA_W-1:0]   r_note;
    logic                r_done;
    logic [DATA_W-1:0]   r_rd_data;

    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_len;
    logic [DUR_W-1:0]    w_word_dur;
    logic [ADDR_W:0]     w_rem_dec;

    // Control strobes produced by the next-state logic.
    logic                w_do_start;   // latch base/len/loop, ptr=base
    logic                w_do_load;    // take fetched word as current note
    logic                w_do_tick;    // beat consumed while playing
    logic                w_do_adv;     // last beat of note: step ptr/rem
    logic                w_do_rewind;  // looping song wraps to its base
    logic                w_done_set;   // non-looping song finished

    assign w_base     = ch_base[c*ADDR_W +: ADDR_W];
    assign w_len      = ch_len[c*ADDR_W +: ADDR_W];
    assign w_word_dur = r_rd_data[DUR_W-1:0];
    assign w_rem_dec  = r_rem - REM_ONE;

    // Next-state and control decode.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
      w_next      = r_state;
      w_do_start  = 1'b0;
      w_do_load   = 1'b0;
      w_do_tick   = 1'b0;
      w_do_adv    = 1'b0;
      w_do_rewind = 1'b0;
      w_done_set  = 1'b0;

      if (ch_stop[c]) begin
        // Stop beats everything, including a simultaneous start.
        w_next = S_IDLE;
      end else if (ch_start[c]) begin
        if (w_len != '0) begin
          w_next     = S_FETCH;
          w_do_start = 1'b1;
        end else begin
          // Empty song: finishes immediately without playing anything.
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end
      end else begin
        unique case (r_state)
          S_IDLE: begin
            w_next = S_IDLE;
          end

          S_FETCH: begin
            // Read of mem[r_ptr] is issued on this edge.
            w_next = S_LOAD;
          end

          S_LOAD: begin
            if (w_word_dur == '0) begin
              // End marker inside the song.
              if (r_loop) begin
                w_next      = S_FETCH;
                w_do_rewind = 1'b1;
              end else begin
                w_next     = S_IDLE;
                w_done_set = 1'b1;
              end
            end else begin
              w_next    = S_PLAY;
              w_do_load = 1'b1;
            end
          end

          S_PLAY: begin
            if (beat_tick) begin
              w_do_tick = 1'b1;
              if (r_dur == DUR_ONE) begin
                w_do_adv = 1'b1;
                if (w_rem_dec != '0) begin
                  w_next = S_FETCH;
                end else if (r_loop) begin
                  w_next      = S_FETCH;
                  w_do_rewind = 1'b1;
                end else begin
                  w_next     = S_IDLE;
                  w_done_set = 1'b1;
                end
              end
            end
          end

          default: begin
            w_next = S_IDLE;
          end
        endcase
      end
    end

    // State register and datapath.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_ptr   <= '0;
        r_rem   <= '0;
        r_base  <= '0;
        r_len   <= '0;
        r_loop  <= 1'b0;
        r_dur   <= '0;
        r_note  <= '0;
        r_done  <= 1'b0;
      end else begin
        r_state <= w_next;
        r_done  <= w_done_set;

        if (w_do_start) begin
          r_ptr  <= w_base;
          r_rem  <= {1'b0, w_len};
          r_base <= w_base;
          r_len  <= w_len;
          r_loop <= ch_loop[c];
        end

        if (w_do_load) begin
          r_note <= r_rd_data;
          r_dur  <= w_word_dur;
        end

        if (w_do_tick) begin
          r_dur <= r_dur - DUR_ONE;
        end

        if (w_do_adv) begin
          r_ptr <= r_ptr + PTR_ONE;
          r_rem <= w_rem_dec;
        end

        // Rewind is decoded after advance so it overrides the pointer step
        // when a looping song ends on a note's last beat.
        if (w_do_rewind) begin
          r_ptr <= r_base;
          r_rem <= {1'b0, r_len};
        end
      end
    end

    // Per-channel synchronous read port, write-first on address collision.
    // The read register is only consumed in LOAD, which always follows a
    // FETCH, so it needs no reset.
    always_ff @(posedge clk) begin
      if (r_state == S_FETCH) begin
        if (wr_en && (wr_addr == r_ptr)) begin
          r_rd_data <= wr_data;
        end else begin
          r_rd_data <= r_mem[r_ptr];
        end
      end
    end

    // ch_valid is high exactly while a note is being played.
    assign ch_note[c*DATA_W +: DATA_W] = r_note;
    assign ch_valid[c]                 = (r_state == S_PLAY);
    assign ch_done[c]                  = r_done;
    assign ch_busy[c]                  = (r_state != S_IDLE);

  end : g_ch

endmodule : note_seq_ram

// File: tb/tb_note_seq_ram.sv
// ---------------------------------------------------------------------------
// tb_note_seq_ram
//
// Directed self-checking bench for note_seq_ram (default parameters).
// A per-cycle monitor logs, for each channel, every note presented (on the
// rising edge of ch_valid), the number of beats it was held, the number of
// low ch_valid cycles between consecutive notes, and ch_done pulses.
// ---------------------------------------------------------------------------
module tb_note_seq_ram;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 8;
  localparam int NCH    = 2;
  localparam int DUR_W  = 5;
  localparam int LOG_N  = 16;

  logic                  clk;
  logic                  rst;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  beat_tick;
  logic [NCH-1:0]        ch_start;
  logic [NCH-1:0]        ch_stop;
  logic [NCH-1:0]        ch_loop;
  logic [NCH*ADDR_W-1:0] ch_base;
  logic [NCH*ADDR_W-1:0] ch_len;
  logic [NCH*DATA_W-1:0] ch_note;
  logic [NCH-1:0]        ch_valid;
  logic [NCH-1:0]        ch_done;
  logic [NCH-1:0]        ch_busy;

  note_seq_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NCH    (NCH),
    .DUR_W  (DUR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .beat_tick (beat_tick),
    .ch_start  (ch_start),
    .ch_stop   (ch_stop),
    .ch_loop   (ch_loop),
    .ch_base   (ch_base),
    .ch_len    (ch_len),
    .ch_note   (ch_note),
    .ch_valid  (ch_valid),
    .ch_done   (ch_done),
    .ch_busy   (ch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Monitor logs
  logic [DATA_W-1:0] note_log [NCH][LOG_N];
  int                tick_log [NCH][LOG_N];
  int                gap_log  [NCH][LOG_N];
  int                note_n   [NCH];
  int                tick_n   [NCH];
  int                gap_n    [NCH];
  int                cur_ticks[NCH];
  int                low_run  [NCH];
  int                done_cnt [NCH];
  int                phase;

  logic [DATA_W-1:0] w0, w1, w2, w_end, wa, wb, wc, wd, we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] word(input int p, input int o, input int d);
    logic [3:0] pp;
    logic [2:0] oo;
    logic [4:0] dd;
    pp = p[3:0];
    oo = o[2:0];
    dd = d[4:0];
    return {pp, oo, dd};
  endfunction

  task automatic clear_logs();
    for (int c = 0; c < NCH; c++) begin
      note_n[c]    = 0;
      tick_n[c]    = 0;
      gap_n[c]     = 0;
      cur_ticks[c] = 0;
      low_run[c]   = 0;
      done_cnt[c]  = 0;
    end
  endtask

  // One clock: outputs are observed 1 time unit after the rising edge,
  // inputs set afterwards are sampled at the following edge. beat_tick
  // pulses every 4th cycle.
  task automatic cyc();
    logic [NCH-1:0] pre_v;
    logic           pre_t;
    pre_v = ch_valid;
    pre_t = beat_tick;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (pre_v[c] && pre_t) cur_ticks[c]++;
      if (ch_valid[c] && !pre_v[c]) begin
        if (note_n[c] > 0 && gap_n[c] < LOG_N) begin
          gap_log[c][gap_n[c]] = low_run[c];
          gap_n[c]++;
        end
        if (note_n[c] < LOG_N) begin
          note_log[c][note_n[c]] = ch_note[c*DATA_W +: DATA_W];
          note_n[c]++;
        end
        cur_ticks[c] = 0;
        low_run[c]   = 0;
      end else if (!ch_valid[c]) begin
        low_run[c]++;
      end
      if (!ch_valid[c] && pre_v[c] && tick_n[c] < LOG_N) begin
        tick_log[c][tick_n[c]] = cur_ticks[c];
        tick_n[c]++;
      end
      if (ch_done[c]) done_cnt[c]++;
    end
    phase     = (phase + 1) % 4;
    beat_tick = (phase == 0);
  endtask

  task automatic wr(input int addr, input logic [DATA_W-1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr[ADDR_W-1:0];
    wr_data = data;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (ch_busy != '0 && k < budget) begin
      cyc();
      k++;
    end
    check({tag, "_idle"}, 32'(ch_busy), 32'd0);
  endtask

  // Compare a completed song on one channel against up to three notes.
  task automatic check_song(input string tag, input int ch, input int n,
                            input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1,
                            input logic [DATA_W-1:0] e2,
                            input int d0, input int d1, input int d2, input int done_exp);
    logic [DATA_W-1:0] en;
    int                ed;
    check({tag, "_nnotes"}, 32'(note_n[ch]), 32'(n));
    check({tag, "_nticks"}, 32'(tick_n[ch]), 32'(n));
    for (int i = 0; i < n; i++) begin
      en = (i == 0) ? e0 : (i == 1) ? e1 : e2;
      ed = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      check($sformatf("%s_note%0d", tag, i), 32'(note_log[ch][i]), 32'(en));
      check($sformatf("%s_beats%0d", tag, i), 32'(tick_log[ch][i]), 32'(ed));
    end
    for (int i = 0; i < n - 1; i++) begin
      check($sformatf("%s_gap%0d", tag, i), 32'(gap_log[ch][i]), 32'd2);
    end
    check({tag, "_done"}, 32'(done_cnt[ch]), 32'(done_exp));
  endtask

  initial begin
    int k;
    logic [DATA_W-1:0] lp [3];
    int                ld [3];

    n_tests   = 0;
    n_fail    = 0;
    phase     = 0;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    beat_tick = 1'b0;
    ch_start  = '0;
    ch_stop   = '0;
    ch_loop   = '0;
    ch_base   = '0;
    ch_len    = '0;
    clear_logs();

    w0    = word(6, 2, 2);
    w1    = word(9, 2, 1);
    w2    = word(4, 1, 3);
    w_end = word(5, 3, 0);
    wa    = word(1, 4, 1);
    wb    = word(11, 5, 3);
    wc    = word(2, 6, 2);
    wd    = word(7, 1, 1);
    we    = word(3, 3, 2);

    cyc();
    cyc();
    // Reset state
    check("rst_note",  32'(ch_note),  32'd0);
    check("rst_valid", 32'(ch_valid), 32'd0);
    check("rst_busy",  32'(ch_busy),  32'd0);
    check("rst_done",  32'(ch_done),  32'd0);
    rst = 1'b0;

    wr(0, w0);
    wr(1, w1);
    wr(2, w2);
    wr(255, wa);
    wr(10, wb);
    wr(11, wc);
    wr(20, wd);

    // ---- Basic song, no loop, exact start latency ----
    clear_logs();
    ch_base  = {8'd0, 8'd0};
    ch_len   = {8'd0, 8'd3};
    ch_loop  = 2'b00;
    ch_start = 2'b01;
    cyc();                              // edge 0
    ch_start = 2'b00;
    check("t1_busy_e0",  32'(ch_busy[0]),  32'd1);
    check("t1_valid_e0", 32'(ch_valid[0]), 32'd0);
    cyc();                              // edge 1
    check("t1_valid_e1", 32'(ch_valid[0]), 32'd0);
    cyc();                              // edge 2
    check("t1_valid_e2", 32'(ch_valid[0]), 32'd1);
    check("t1_note_e2",  32'(ch_note[DATA_W-1:0]), 32'(w0));
    run_until_idle("t1", 300);
    check_song("t1", 0, 3, w0, w1, w2, 2, 1, 3, 1);
    check("t1_note_hold", 32'(ch_note[DATA_W-1:0]), 32'(w2));

    // ---- Looping song, then stop ----
    clear_logs();
    ch_loop  = 2'b01;
    ch_start = 2'b01;
    cyc();
    ch_start = 2'b00;
    k = 0;
    while (note_n[0] < 7 && k < 600) begin
      cyc();
      k++;
    end
    check("t2_notes_seen", 32'(note_n[0]), 32'd7);
    lp[0] = w0; lp[1] = w1; lp[2] = w2;
    ld[0] = 2;  ld[1] = 1;  ld[2] = 3;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t2_note%0d", i), 32'(note_log[0][i]), 32'(lp[i % 3]));
    end
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_beats%0d", i), 32'(tick_log[0][i]), 32'(ld[i % 3]));
    end
    check("t2_valid_pre_stop", 32'(ch_valid[0]), 32'd1);
    ch_stop = 2'b01;
    cyc();
    ch_stop = 2'b00;
    check("t2_stop_valid", 32'(ch_valid[0]), 32'd0);
    check("t2_stop_busy",  32'(ch_busy[0]),  32'd0);
    cyc();
    cyc();
    check("t2_no_done", 32'(done_cnt[0]), 32'd0);

    // ---- End marker inside the song ----
    wr(1, w_end);
    clear_logs();
    ch_loop  = 2'b00;
    ch_start = 2'b01;
    cyc();
    ch_start = 2'b00;
    run_until_idle("t3", 300);
    check_song("t3", 0, 1, w0, w0, w0, 2, 0, 0, 1);
    check("t3_note_hold", 32'(ch_note[DATA_W-1:0]), 32'(w0));
    wr(1, w1);

    // ---- Address wrap at top of memory ----
    clear_logs();
    ch_base  = {8'd0, 8'd255};
    ch_len   = {8'd0, 8'd2};
    ch_start = 2'b01;
    cyc();
    ch_start = 2'b00;
    run_until_idle("t4", 300);
    check_song("t4", 0, 2, wa, w0, w0, 1, 2, 0, 1);

    // ---- Two channels, staggered starts ----
    clear_logs();
    ch_base  = {8'd10, 8'd0};
    ch_len   = {8'd2, 8'd3};
    ch_start = 2'b01;
    cyc();
    ch_start = 2'b00;
    cyc();
    ch_start = 2'b10;
    cyc();
    ch_start = 2'b00;
    run_until_idle("t5", 400);
    check_song("t5c0", 0, 3, w0, w1, w2, 2, 1, 3, 1);
    check_song("t5c1", 1, 2, wb, wc, wc, 3, 2, 0, 1);

    // ---- Write to the address being fetched (write-first) ----
    clear_logs();
    ch_base  = {8'd0, 8'd20};
    ch_len   = {8'd0, 8'd1};
    ch_start = 2'b01;
    cyc();                              // edge 0, now in FETCH
    ch_start = 2'b00;
    wr_en    = 1'b1;
    wr_addr  = 8'd20;
    wr_data  = we;
    cyc();                              // edge 1: read + write same address
    wr_en    = 1'b0;
    cyc();                              // edge 2
    check("t6_valid", 32'(ch_valid[0]), 32'd1);
    check("t6_note",  32'(ch_note[DATA_W-1:0]), 32'(we));
    run_until_idle("t6", 300);

    // ---- Reset mid-play, memory retained ----
    clear_logs();
    ch_base  = {8'd10, 8'd0};
    ch_len   = {8'd2, 8'd3};
    ch_loop  = 2'b11;
    ch_start = 2'b11;
    cyc();
    ch_start = 2'b00;
    k = 0;
    while (ch_valid != 2'b11 && k < 200) begin
      cyc();
      k++;
    end
    check("t7_both_playing", 32'(ch_valid), 32'd3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t7_rst_note",  32'(ch_note),  32'd0);
    check("t7_rst_valid", 32'(ch_valid), 32'd0);
    check("t7_rst_busy",  32'(ch_busy),  32'd0);
    check("t7_rst_done",  32'(ch_done),  32'd0);
    clear_logs();
    ch_loop  = 2'b00;
    ch_start = 2'b01;
    cyc();
    ch_start = 2'b00;
    run_until_idle("t7", 300);
    check_song("t7", 0, 3, w0, w1, w2, 2, 1, 3, 1);

    // ---- Start and stop together: stop wins ----
    clear_logs();
    ch_start = 2'b01;
    ch_stop  = 2'b01;
    cyc();
    ch_start = 2'b00;
    ch_stop  = 2'b00;
    check("t8_busy", 32'(ch_busy[0]), 32'd0);
    cyc();
    check("t8_busy2", 32'(ch_busy[0]), 32'd0);
    check("t8_done",  32'(done_cnt[0]), 32'd0);

    // ---- Zero-length start: immediate done, never busy ----
    clear_logs();
    ch_len   = {8'd0, 8'd0};
    ch_start = 2'b01;
    cyc();
    ch_start = 2'b00;
    check("t9_done",  32'(ch_done[0]),  32'd1);
    check("t9_busy",  32'(ch_busy[0]),  32'd0);
    check("t9_valid", 32'(ch_valid[0]), 32'd0);
    cyc();
    check("t9_done_pulse", 32'(ch_done[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_note_seq_ram

// File: doc/note_seq_ram.md
Name: note_seq_ram

Overview:
- Parametrised note memory with NCH independent playback channels. It succeeds the single-song 12-bit note store.
- Note word layout: pitch [DATA_W-1:DATA_W-4], octave [DATA_W-5:DUR_W], duration [DUR_W-1:0].
- One write port loads songs. Each channel runs its own read pointer and duration counter and presents the current note to its tone generator.

Parameters:
- DATA_W, 12, note word width; must be ≥ DUR_W+7.
- ADDR_W, 8, address width; depth = 2^ADDR_W.
- NCH, 2, number of playback channels.
- DUR_W, 5, duration field width in beats.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  note word to write.
- beat_tick  in  1  one-cycle beat pulse, shared by all channels.
- ch_start  in  NCH  per-channel start pulse.
- ch_stop  in  NCH  per-channel stop pulse.
- ch_loop  in  NCH  per-channel loop enable, sampled on start.
- ch_base  in  NCH*ADDR_W  per-channel song base address, sampled on start.
- ch_len  in  NCH*ADDR_W  per-channel song length in notes, sampled on start.
- ch_note  out  NCH*DATA_W  current note word per channel.
- ch_valid  out  NCH  note on ch_note is playing.
- ch_done  out  NCH  one-cycle pulse when a non-looping song ends.
- ch_busy  out  NCH  channel not IDLE.

Behaviour:
- Memory array is 2^ADDR_W x DATA_W and is never cleared by rst.
- Write: on a clk edge with wr_en, mem[wr_addr] <= wr_data.
- Reads: one synchronous read port per channel, 1-cycle latency.
- Write/read collision: a read of the address being written in the same cycle returns wr_data (write-first).
- Reset (any time, including mid-song): all channels go to IDLE. ch_note=0, ch_valid=0, ch_done=0, ch_busy=0. Pointers and counters cleared.
- Per-channel state machine: IDLE -> FETCH -> LOAD -> PLAY.
- IDLE:
  - ch_start with ch_len≠0: latch ptr=base, rem=len, loop; go to FETCH.
  - ch_start with ch_len=0: ch_done pulses next cycle; stay IDLE; ch_valid stays 0.
- FETCH: issue a read at ptr; ch_valid=0; go to LOAD.
- LOAD: read data arrives.
  - If duration field = 0 (end marker): apply end handling.
  - Otherwise: ch_note<=word, dur<=duration, ch_valid<=1, go to PLAY.
- PLAY:
  - On each beat_tick, dur decrements.
  - A tick with dur==1 advances: ptr<=ptr+1 (wraps mod 2^ADDR_W), rem<=rem-1, ch_valid<=0.
  - If rem after decrement ≠ 0: go to FETCH. Otherwise apply end handling.
- End handling:
  - loop=1: ptr<=base, rem<=len, go to FETCH; no done pulse.
  - loop=0: ch_done pulse for 1 cycle, ch_valid=0, go to IDLE. ch_note holds its last value.
- beat_tick is ignored in IDLE, FETCH and LOAD.
- Timing: start sampled at edge 0 -> read issued in cycle 1 -> ch_valid=1 from edge 2. Between consecutive notes ch_valid is low for exactly 2 cycles.
- ch_stop in any state: go to IDLE next cycle, ch_valid=0, no ch_done.
- ch_start while busy: restart from the new base/len.
- Start and stop asserted in the same cycle: stop wins.
- Channels are fully independent. Several channels may read the same address in the same cycle.
- ch_busy = (state≠IDLE).
- Width rules:
  - dur is DUR_W bits; rem is ADDR_W+1 bits internally.
  - ch_len=2^ADDR_W-1 is the maximum; no channel wraps past base+len.

Test Plan:
- Load mem[0..2] = {pitch 6/oct 2/dur 2, pitch 9/oct 2/dur 1, pitch 4/oct 1/dur 3}. Start ch0, base=0, len=3, loop=0, beat_tick every 4 cycles. Required: ch_valid high at edge 2; notes appear in order for 2/1/3 ticks; ch_done pulses once; ch_busy falls.
- Same song with loop=1, run for 15 ticks -> note sequence repeats with period 6 ticks; no ch_done; ch_stop -> ch_valid=0 next cycle, no done.
- Word with duration 0 at address 1, len=3 -> after note 0, channel ends (done pulse if loop=0); note at address 2 is never presented.
- base=2^ADDR_W-1, len=2 -> second fetch reads address 0 (wrap).
- ch0 and ch1 started together on different songs with interleaved ticks -> independent correct outputs. wr_en to ch0's fetch address in its FETCH cycle -> ch_note shows the new wr_data.
- rst asserted mid-PLAY -> all outputs 0 next edge. Memory contents intact: restart replays the same notes. Start and stop in the same cycle -> channel stays IDLE.
